// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter: two-requester issue arbiter in front of a fixed-latency
// single-precision FPU. Accepts one operation per cycle, issues it to the
// datapath, tracks the owner alongside the FPU pipeline and returns the
// result to that owner. Includes a RUN/DRAIN/HALT drain controller.
// Optional feature: define FPU_ISSUE_ARB_RR_EN for round-robin arbitration
// (default build uses fixed priority, A over B).
module fpu_issue_arbiter #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [31:0] a_opa_i,
  input  logic [31:0] a_opb_i,
  input  logic [1:0]  a_op_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  input  logic [31:0] b_opa_i,
  input  logic [31:0] b_opb_i,
  input  logic [1:0]  b_op_i,
  output logic        fpu_valid_o,
  output logic [31:0] fpu_opa_o,
  output logic [31:0] fpu_opb_o,
  output logic [1:0]  fpu_op_o,
  input  logic [31:0] fpu_res_i,
  output logic        a_res_valid_o,
  output logic        b_res_valid_o,
  output logic [31:0] res_o,
  input  logic        drain_i,
  output logic        drained_o,
  output logic [3:0]  inflight_o
);

  localparam int unsigned LAST = LATENCY - 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               grant_a;
  logic               grant_b;
  logic               acc_a;
  logic               acc_b;
  logic               accept;
  logic               res_done;
  logic               issue_b_q;
  logic [LATENCY-1:0] tag_v_q;
  logic [LATENCY-1:0] tag_b_q;
  logic [3:0]         inflight_q;

`ifdef FPU_ISSUE_ARB_RR_EN
  logic rr_prefer_b_q;

  // Round-robin grant: on contention, serve whoever was not served last
  always_comb begin
    grant_a = a_valid_i & (~b_valid_i | ~rr_prefer_b_q);
    grant_b = b_valid_i & (~a_valid_i | rr_prefer_b_q);
  end

  // Pointer moves only on an actual acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rr_prefer_b_q <= 1'b0;
    else if (accept) rr_prefer_b_q <= acc_a;
  end
`else
  // Fixed priority grant: A always wins
  always_comb begin
    grant_a = a_valid_i;
    grant_b = b_valid_i & ~a_valid_i;
  end
`endif

  assign a_ready_o  = (state_q == ST_RUN) & grant_a;
  assign b_ready_o  = (state_q == ST_RUN) & grant_b;
  assign acc_a      = a_valid_i & a_ready_o;
  assign acc_b      = b_valid_i & b_ready_o;
  assign accept     = acc_a | acc_b;
  assign res_done   = a_res_valid_o | b_res_valid_o;
  assign drained_o  = (state_q == ST_HALT);
  assign inflight_o = inflight_q;

  // Issue register: one-cycle valid pulse, operands held between issues
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_valid_o <= 1'b0;
      issue_b_q   <= 1'b0;
      fpu_opa_o   <= '0;
      fpu_opb_o   <= '0;
      fpu_op_o    <= '0;
    end else begin
      fpu_valid_o <= accept;
      if (accept) begin
        issue_b_q <= acc_b;
        fpu_opa_o <= acc_b ? b_opa_i : a_opa_i;
        fpu_opb_o <= acc_b ? b_opb_i : a_opb_i;
        fpu_op_o  <= acc_b ? b_op_i  : a_op_i;
      end
    end
  end

  // Owner tag pipeline; the issue register acts as its head stage, so the
  // last stage lines up with the cycle in which fpu_res_i is meaningful
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v_q <= '0;
      tag_b_q <= '0;
    end else begin
      tag_v_q[0] <= fpu_valid_o;
      tag_b_q[0] <= issue_b_q;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_b_q[i] <= tag_b_q[i-1];
      end
    end
  end

  // Result capture and one-cycle return pulse to the owning requester
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_res_valid_o <= 1'b0;
      b_res_valid_o <= 1'b0;
      res_o         <= '0;
    end else begin
      a_res_valid_o <= tag_v_q[LAST] & ~tag_b_q[LAST];
      b_res_valid_o <= tag_v_q[LAST] &  tag_b_q[LAST];
      if (tag_v_q[LAST]) res_o <= fpu_res_i;
    end
  end

  // Outstanding count: up on acceptance, down once the return pulse is seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
    end else begin
      case ({accept, res_done})
        2'b10:   inflight_q <= inflight_q + 4'd1;
        2'b01:   inflight_q <= inflight_q - 4'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Drain controller next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_i)             state_d = ST_DRAIN;
      ST_DRAIN: if (inflight_q == '0)    state_d = ST_HALT;
      ST_HALT:  if (!drain_i)            state_d = ST_RUN;
      default:                           state_d = ST_RUN;
    endcase
  end

  // Drain controller state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

endmodule
